// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit.
//
// Purpose:
//   Holds the funct3 size and unsigned-flag constants, the FSM state enum,
//   and the default DMem capacity. Both dmem_access_unit and dmem_lane_unit
//   import this package.
//
// Contents:
//   DMEM_DW            data/address width (64)
//   MEM_BYTES_DEFAULT  default DMem capacity in bytes
//   F3_B..F3_D         funct3[1:0] access sizes (1/2/4/8 bytes)
//   F3_UNS             bit index of the unsigned-load flag in funct3
//   F3_ILLEGAL         the one funct3 value that no access uses
//   state_e            IDLE / READ / WRITE / DONE
package dmem_pkg;

  localparam int              DMEM_DW           = 64;
  localparam longint unsigned MEM_BYTES_DEFAULT = 64'd1048576;

  localparam logic [1:0] F3_B = 2'b00;
  localparam logic [1:0] F3_H = 2'b01;
  localparam logic [1:0] F3_W = 2'b10;
  localparam logic [1:0] F3_D = 2'b11;

  localparam int         F3_UNS     = 2;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane logic for the data-memory access unit.
//
// Purpose:
//   Purely combinational. From the doubleword read at the access address,
//   it builds two results:
//     - the load value, sign- or zero-extended to 64 bits
//     - the store word for the read-modify-write of a sub-doubleword store
//
// Ports:
//   funct3_i  [2:0]   access size in [1:0]; bit 2 selects a zero-extending load
//   rdata_i   [63:0]  doubleword that DMem returns at the access address
//   wdata_i   [63:0]  store data; only the low 1/2/4/8 bytes are used
//   load_o    [63:0]  extended load result
//   store_o   [63:0]  store data in the low bytes, rdata_i in the upper bytes
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [63:0] rdata_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_o,
  output logic [63:0] store_o
);

  // The extension bit is the top bit of the loaded field.
  // It is forced to 0 for unsigned loads.
  logic uns;

  assign uns = funct3_i[F3_UNS];

  // The access is little-endian from the base address, so the loaded or
  // stored field always lives in the low bytes of the doubleword.
  always_comb begin
    load_o  = rdata_i;
    store_o = wdata_i;
    case (funct3_i[1:0])
      F3_B: begin
        load_o  = {{56{rdata_i[7] & ~uns}}, rdata_i[7:0]};
        store_o = {rdata_i[63:8], wdata_i[7:0]};
      end
      F3_H: begin
        load_o  = {{48{rdata_i[15] & ~uns}}, rdata_i[15:0]};
        store_o = {rdata_i[63:16], wdata_i[15:0]};
      end
      F3_W: begin
        load_o  = {{32{rdata_i[31] & ~uns}}, rdata_i[31:0]};
        store_o = {rdata_i[63:32], wdata_i[31:0]};
      end
      default: begin
        load_o  = rdata_i;
        store_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Initiator side of the 64-bit byte-addressed data-memory interface.
//
// Purpose:
//   Takes one load or store request at a time from the execute stage and
//   turns it into DMem cycles.
//   - Loads: read once and extend the result.
//   - Doubleword stores: write directly.
//   - Byte, halfword and word stores: read, merge, then write back, because
//     DMem always writes 8 bytes.
//   - Illegal funct3 values and out-of-range addresses finish in one cycle
//     with out_err set, and never touch DMem.
//
// Ports:
//   in_clk, in_rst       clock (rising edge); reset (asynchronous, active-high)
//   in_req               request valid; taken only while out_ready is 1
//   in_we                1 = store, 0 = load
//   in_funct3 [2:0]      [1:0] size, [2] unsigned (loads only)
//   in_addr   [63:0]     byte address, any alignment
//   in_wdata  [63:0]     store data
//   out_ready            1 only in IDLE
//   out_done             one-cycle completion pulse
//   out_err              valid with out_done
//   out_rdata [63:0]     last successful load result
//   out_mem_addr  [63:0] DMem address
//   out_mem_data  [63:0] DMem write data
//   out_mem_wr_en        DMem write enable, high only in WRITE
//   in_mem_data   [63:0] DMem combinational read data
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int              DATA_WIDTH = DMEM_DW,
  parameter longint unsigned MEM_BYTES  = MEM_BYTES_DEFAULT
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_req,
  input  logic                  in_we,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  out_ready,
  output logic                  out_done,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0] out_mem_data,
  output logic                  out_mem_wr_en,
  input  logic [DATA_WIDTH-1:0] in_mem_data
);

  // Highest legal base address. Every access touches 8 bytes in DMem, even
  // when only some of them are used.
  localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES) - 64'd8;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        err_q;
  logic [63:0] rdata_q;
  logic [63:0] mem_data_q;

  logic        accept;
  logic        req_err;
  logic        req_dword;
  logic [63:0] load_val;
  logic [63:0] store_word;

  assign accept    = in_req & (state_q == ST_IDLE);
  assign req_dword = (in_funct3[1:0] == F3_D);

  // A store with the unsigned flag has no meaning. The address check is an
  // unsigned 64-bit compare, so wrapped addresses are also caught.
  assign req_err = (in_funct3 == F3_ILLEGAL)
                 | (in_we & in_funct3[F3_UNS])
                 | (in_addr > ADDR_LIMIT);

  dmem_lane_unit u_lane (
    .funct3_i (funct3_q),
    .rdata_i  (in_mem_data),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .store_o  (store_word)
  );

  // State register
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // Doubleword stores skip READ, because no existing bytes need to survive.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = ST_DONE;
          end else if (in_we && req_dword) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = we_q ? ST_WRITE : ST_DONE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode.
  // The write enable depends on state only, so no input can glitch it high.
  always_comb begin
    out_ready     = (state_q == ST_IDLE);
    out_done      = (state_q == ST_DONE);
    out_err       = (state_q == ST_DONE) & err_q;
    out_mem_wr_en = (state_q == ST_WRITE);
  end

  assign out_rdata    = rdata_q;
  assign out_mem_addr = addr_q;
  assign out_mem_data = mem_data_q;

  // Request latches and datapath registers.
  // - mem_data_q is loaded at accept for a doubleword store.
  // - Otherwise mem_data_q is loaded at the end of READ, so that it is
  //   stable for the whole WRITE cycle.
  // - rdata_q changes only when a load completes its READ.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      err_q      <= 1'b0;
      rdata_q    <= 64'd0;
      mem_data_q <= 64'd0;
    end else begin
      if (accept) begin
        we_q     <= in_we;
        funct3_q <= in_funct3;
        addr_q   <= in_addr;
        wdata_q  <= in_wdata;
        err_q    <= req_err;
        if (in_we && req_dword && !req_err) begin
          mem_data_q <= in_wdata;
        end
      end
      if (state_q == ST_READ) begin
        if (we_q) begin
          mem_data_q <= store_word;
        end else begin
          rdata_q <= load_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomised scoreboard bench for dmem_access_unit.
//
// Components:
//   - A byte-array DMem model serves the DUT's combinational reads and
//     8-byte writes.
//   - A separate byte-level reference memory is updated from the access
//     rules at issue time.
//   - Each request pushes its expected error flag, result, latency and
//     write count into a queue.
//   - A negedge monitor pops and compares on every out_done.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  localparam int          MEM_SIZE = 1048576;
  localparam logic [63:0] TOP      = 64'd1048576;

  logic        clock = 1'b0;
  logic        reset;
  logic        inReq, inWe;
  logic [2:0]  inFunct3;
  logic [63:0] inAddr, inWdata;
  logic        outReady, outDone, outErr, memWrEn;
  logic [63:0] outRdata, memAddr, memWdata, memRdata;

  always #5 clock = ~clock;

  dmem_access_unit #(.DATA_WIDTH(64), .MEM_BYTES(64'd1048576)) dut (
    .in_clk        (clock),
    .in_rst        (reset),
    .in_req        (inReq),
    .in_we         (inWe),
    .in_funct3     (inFunct3),
    .in_addr       (inAddr),
    .in_wdata      (inWdata),
    .out_ready     (outReady),
    .out_done      (outDone),
    .out_err       (outErr),
    .out_rdata     (outRdata),
    .out_mem_addr  (memAddr),
    .out_mem_data  (memWdata),
    .out_mem_wr_en (memWrEn),
    .in_mem_data   (memRdata)
  );

  // DMem model.
  // - Reads are combinational and little-endian from the base address.
  // - Writes store 8 bytes at the clock edge.
  // - Preloads enter through the same block.
  logic [7:0]  dmem [0:MEM_SIZE-1];
  logic        preloadEn = 1'b0;
  logic [63:0] preloadAddr = 64'd0;
  logic [63:0] preloadData = 64'd0;

  always_comb begin
    memRdata = 64'd0;
    if (memAddr <= TOP - 64'd8) begin
      for (int i = 0; i < 8; i++) begin
        memRdata[8*i +: 8] = dmem[int'(memAddr[19:0]) + i];
      end
    end
  end

  always @(posedge clock) begin
    if (preloadEn) begin
      for (int i = 0; i < 8; i++) begin
        dmem[int'(preloadAddr[19:0]) + i] <= preloadData[8*i +: 8];
      end
    end else if (memWrEn && memAddr <= TOP - 64'd8) begin
      for (int i = 0; i < 8; i++) begin
        dmem[int'(memAddr[19:0]) + i] <= memWdata[8*i +: 8];
      end
    end
  end

  // Reference model state and scoreboard.
  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          latency;
    int          writes;
    int          id;
  } exp_t;

  exp_t        expQ[$];
  logic [7:0]  refMem [longint];
  logic [63:0] lastRdata = 64'd0;
  int          testCount = 0;
  int          failCount = 0;
  int          txnId = 0;
  int          cycle = 0;
  int          acceptCycle = 0;
  int          wrCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] refRead(input logic [63:0] addr, input int nBytes);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < nBytes; i++) begin
      v[8*i +: 8] = refMem.exists(longint'(addr) + i) ? refMem[longint'(addr) + i] : 8'h00;
    end
    return v;
  endfunction

  task automatic preload(input logic [63:0] addr, input logic [63:0] data);
    for (int i = 0; i < 8; i++) refMem[longint'(addr) + i] = data[8*i +: 8];
    preloadAddr = addr;
    preloadData = data;
    preloadEn   = 1'b1;
    @(posedge clock); #1;
    preloadEn   = 1'b0;
  endtask

  // Computes the expected outcome from the access rules, queues it, and
  // issues the request once the unit is ready.
  // Called at posedge+1.
  task automatic applyStimulus(input bit we, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata);
    exp_t                e;
    int                  nBytes;
    int                  sh;
    int                  guard;
    logic signed [63:0]  t;
    nBytes = 1 << f3[1:0];
    e.id   = txnId++;
    e.err  = (f3 == 3'b111) || (we && f3[2]) || (addr > TOP - 64'd8);
    if (e.err) begin
      e.latency = 1; e.writes = 0; e.rdata = lastRdata;
    end else if (!we) begin
      sh = 64 - 8 * nBytes;
      t  = signed'(refRead(addr, nBytes) << sh);
      t  = f3[2] ? signed'(64'(unsigned'(t) >> sh)) : (t >>> sh);
      lastRdata = t;
      e.latency = 2; e.writes = 0; e.rdata = lastRdata;
    end else begin
      for (int i = 0; i < nBytes; i++) refMem[longint'(addr) + i] = wdata[8*i +: 8];
      e.latency = (nBytes == 8) ? 2 : 3; e.writes = 1; e.rdata = lastRdata;
    end
    guard = 0;
    while (!outReady && guard < 30) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!outReady) begin
      testCount++; failCount++;
      $display("[TB] FAIL ready timeout txn%0d: got out_ready=0, expected 1", e.id);
      return;
    end
    expQ.push_back(e);
    inReq = 1'b1; inWe = we; inFunct3 = f3; inAddr = addr; inWdata = wdata;
    @(posedge clock); #1;
    inReq = 1'b0;
  endtask

  // Monitor: tracks accept time and write pulses, and scores every
  // completion.
  always @(negedge clock) begin
    if (reset) begin
      wrCount = 0;
    end else begin
      exp_t e;
      cycle++;
      if (memWrEn) wrCount++;
      if (inReq && outReady) begin
        acceptCycle = cycle;
        wrCount     = 0;
      end
      if (outDone) begin
        if (expQ.size() == 0) begin
          testCount++; failCount++;
          $display("[TB] FAIL unexpected done: got out_done=1, expected 0");
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("txn%0d err", e.id), 64'(outErr), 64'(e.err));
          checkOutput($sformatf("txn%0d rdata", e.id), outRdata, e.rdata);
          checkOutput($sformatf("txn%0d latency", e.id), 64'(cycle - acceptCycle), 64'(e.latency));
          checkOutput($sformatf("txn%0d writes", e.id), 64'(wrCount), 64'(e.writes));
        end
      end
    end
  end

  initial begin
    logic [63:0] a;
    int          pick;
    int          guard;
    reset = 1'b1; inReq = 1'b0; inWe = 1'b0; inFunct3 = 3'b000; inAddr = 64'd0; inWdata = 64'd0;
    @(posedge clock); #1;
    checkOutput("reset ready", 64'(outReady), 64'd1);
    checkOutput("reset done", 64'(outDone), 64'd0);
    checkOutput("reset err", 64'(outErr), 64'd0);
    checkOutput("reset wr_en", 64'(memWrEn), 64'd0);
    checkOutput("reset rdata", outRdata, 64'd0);
    checkOutput("reset mem_addr", memAddr, 64'd0);
    checkOutput("reset mem_data", memWdata, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Fill the working window and the top doubleword, then place the
    // directed patterns.
    for (int i = 0; i < 257; i++) preload(64'(i * 8), {$urandom, $urandom});
    preload(TOP - 64'd8, {$urandom, $urandom});
    preload(64'h100, 64'h0123456789ABCDEF);
    preload(64'h10,  64'h5555555555555580);
    preload(64'h20,  64'h1234567880000000);
    preload(64'h200, 64'h1111111111111111);

    // Directed loads, stores and readbacks.
    applyStimulus(0, 3'b011, 64'h100, 64'd0);
    applyStimulus(0, 3'b000, 64'h10, 64'd0);
    applyStimulus(0, 3'b100, 64'h10, 64'd0);
    applyStimulus(0, 3'b110, 64'h20, 64'd0);
    applyStimulus(0, 3'b010, 64'h20, 64'd0);
    applyStimulus(1, 3'b001, 64'h200, 64'h000000000000ABCD);
    applyStimulus(0, 3'b011, 64'h200, 64'd0);
    applyStimulus(1, 3'b011, 64'h300, 64'hDEADBEEFCAFEF00D);
    applyStimulus(0, 3'b011, 64'h300, 64'd0);
    applyStimulus(1, 3'b000, 64'h305, 64'h00000000000000A5);
    applyStimulus(0, 3'b011, 64'h300, 64'd0);

    // Error cases and the address boundary.
    applyStimulus(0, 3'b111, 64'h100, 64'd0);
    applyStimulus(1, 3'b100, 64'h200, 64'h77);
    applyStimulus(0, 3'b011, TOP - 64'd7, 64'd0);
    applyStimulus(0, 3'b011, TOP - 64'd8, 64'd0);
    applyStimulus(1, 3'b011, TOP - 64'd8, 64'hA5A5A5A5A5A5A5A5);
    applyStimulus(0, 3'b000, TOP - 64'd8, 64'd0);
    applyStimulus(1, 3'b010, 64'hFFFFFFFFFFFFFFFC, 64'h1);

    // Reset during the WRITE cycle of a word store.
    guard = 0;
    while (!outReady && guard < 30) begin @(posedge clock); #1; guard++; end
    inReq = 1'b1; inWe = 1'b1; inFunct3 = 3'b010; inAddr = 64'h40; inWdata = 64'hCAFEBABE;
    @(posedge clock); #1;
    inReq = 1'b0;
    @(posedge clock); #1;
    checkOutput("pre-reset wr_en", 64'(memWrEn), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid-reset wr_en", 64'(memWrEn), 64'd0);
    checkOutput("mid-reset ready", 64'(outReady), 64'd1);
    checkOutput("mid-reset done", 64'(outDone), 64'd0);
    checkOutput("mid-reset rdata", outRdata, 64'd0);
    lastRdata = 64'd0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    applyStimulus(0, 3'b011, 64'h40, 64'd0);

    // Randomised traffic, mostly inside the working window.
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 19);
      if (pick < 17) a = 64'($urandom_range(0, 32'h7F8));
      else if (pick == 17) a = TOP - 64'd8;
      else if (pick == 18) a = TOP - 64'($urandom_range(1, 7));
      else a = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom});
    end

    guard = 0;
    while (expQ.size() != 0 && guard < 20) begin @(posedge clock); #1; guard++; end
    if (expQ.size() != 0) begin
      testCount++; failCount++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
